// File: rtl/avalmm_master_ctrl.sv
`default_nettype none
// ============================================================================
// avalmm_master_ctrl : single-outstanding Avalon-MM master, fixed read latency,
//                      waitrequest timeout.                        Rev 1.0
// ============================================================================
module avalmm_master_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [2:0]  c_LAT_INIT = 3'(RD_LATENCY - 1);
  localparam logic [16:0] c_TIMEOUT  = 17'(TIMEOUT);

  state_t              state_q;
  logic [15:0]         stall_q;
  logic [2:0]          lat_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic [ADDR_W-1:0]   avm_address_q;
  logic                avm_write_q;
  logic                avm_read_q;
  logic [DATA_W-1:0]   avm_writedata_q;

  // One bit wider than the counter so TIMEOUT=65535 compares without wrap.
  logic [16:0] w_stall_inc;
  assign w_stall_inc = {1'b0, stall_q} + 17'd1;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      stall_q         <= '0;
      lat_q           <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      avm_address_q   <= '0;
      avm_write_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            avm_address_q   <= cmd_addr;
            avm_writedata_q <= cmd_wdata;
            avm_write_q     <= cmd_write;
            avm_read_q      <= !cmd_write;
            stall_q         <= '0;
            cmd_ready_q     <= 1'b0;
            state_q         <= BUS;
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            avm_write_q <= 1'b0;
            avm_read_q  <= 1'b0;
            if (avm_read_q) begin
              lat_q   <= c_LAT_INIT;
              state_q <= RD_WAIT;
            end else begin
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end else if (w_stall_inc >= c_TIMEOUT) begin
            // Abandon the stalled transfer and report it as an error.
            avm_write_q <= 1'b0;
            avm_read_q  <= 1'b0;
            stall_q     <= w_stall_inc[15:0];
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            stall_q <= w_stall_inc[15:0];
          end
        end
        RD_WAIT: begin
          if (lat_q == 3'd0) begin
            rsp_rdata_q <= avm_readdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        RESP: begin
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign avm_address   = avm_address_q;
  assign avm_write     = avm_write_q;
  assign avm_read      = avm_read_q;
  assign avm_writedata = avm_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_avalmm_master_ctrl.sv
`default_nettype none
// ============================================================================
// tb_avalmm_master_ctrl : two instances (read latency 1 and 3, timeout 8) fed
//                         the same command stream, checked against a queue.
// ============================================================================
module tb_avalmm_master_ctrl;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          nwait;
    bit          busy;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          nstrobe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        waitreq;

  logic        cmd_ready     [2];
  logic        rsp_valid     [2];
  logic [31:0] rsp_rdata     [2];
  logic        rsp_err       [2];
  logic [4:0]  avm_address   [2];
  logic        avm_write     [2];
  logic        avm_read      [2];
  logic [31:0] avm_writedata [2];
  logic [31:0] avm_readdata  [2];

  logic [31:0] mem [32];
  logic [31:0] p0 [2];
  logic [31:0] p1 [2];
  logic [31:0] p2 [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    avalmm_master_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .RD_LATENCY(g == 0 ? 1 : 3), .TIMEOUT(TIMEOUT)
    ) u_dut (
      .sys_clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .avm_address(avm_address[g]), .avm_write(avm_write[g]), .avm_read(avm_read[g]),
      .avm_writedata(avm_writedata[g]), .avm_readdata(avm_readdata[g]),
      .avm_waitrequest(waitreq)
    );
    // Read data is valid only on the single cycle RD_LATENCY after acceptance.
    assign avm_readdata[g] = (g == 0) ? p0[g] : p2[g];
  end

  // Slave model: memory plus a readdata delay line, junk when not valid.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'h0001_F4A0 : 32'h1000_0000 + 32'(i);
    end else if (avm_write[0] && !waitreq) begin
      mem[avm_address[0]] <= avm_writedata[0];
    end
    for (int g = 0; g < 2; g++) begin
      p0[g] <= (avm_read[g] && !waitreq) ? mem[avm_address[g]] : 32'hDEAD_BEEF;
      p1[g] <= p0[g];
      p2[g] <= p1[g];
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issued = 0;
  exp_t sb[$];
  int   idx [2];
  int   st_cnt [2];
  int   last_st [2];
  int   strobes [2];
  int   rsps [2];
  bit   st_act [2];
  bit   st_wr [2];
  logic [4:0]  st_addr [2];
  logic [31:0] st_data [2];
  vec_t vecs [9];

  task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, g, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        st_act[g] = 1'b0;
        idx[g]    = sb.size();
        continue;
      end
      if (avm_read[g] || avm_write[g]) begin
        if (!st_act[g]) begin
          st_act[g]  = 1'b1;
          st_cnt[g]  = 1;
          st_addr[g] = avm_address[g];
          st_data[g] = avm_writedata[g];
          st_wr[g]   = avm_write[g];
          strobes[g]++;
        end else begin
          st_cnt[g]++;
          chk("hold_addr", g, 32'({avm_write[g], avm_address[g]}), 32'({st_wr[g], st_addr[g]}));
          chk("hold_wdata", g, avm_writedata[g], st_data[g]);
        end
        chk("rw_excl", g, 32'(avm_read[g] & avm_write[g]), 32'd0);
        chk("ready_busy", g, 32'(cmd_ready[g]), 32'd0);
        last_st[g] = cyc;
      end else begin
        st_act[g] = 1'b0;
      end
      if (rsp_valid[g]) begin
        rsps[g]++;
        if (idx[g] >= sb.size()) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got rsp_valid 1 expected 0", g);
        end else begin
          e = sb[idx[g]];
          idx[g]++;
          chk("rsp_rdata", g, rsp_rdata[g], e.rdata);
          chk("rsp_err", g, 32'(rsp_err[g]), 32'(e.err));
          chk("strobe_len", g, 32'(st_cnt[g]), 32'(e.nstrobe));
          chk("bus_cmd", g, 32'({st_wr[g], st_addr[g]}), 32'({e.wr, e.addr}));
          chk("bus_wdata", g, st_data[g], e.wdata);
          chk("addr_at_rsp", g, 32'(avm_address[g]), 32'(e.addr));
          chk("rsp_delay", g, 32'(cyc - last_st[g]),
              32'((e.err || e.wr) ? 1 : ((g == 0) ? 2 : 4)));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic run_cmd(vec_t v);
    exp_t e;
    int   k;
    bit   done;
    k = 0;
    while (!(cmd_ready[0] && cmd_ready[1]) && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got cmd_ready 0 expected 1");
    end
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    waitreq   = 1'b0;
    e.wr = v.wr; e.addr = v.addr; e.wdata = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err;
    e.nstrobe = v.exp_err ? TIMEOUT : v.nwait + 1;
    sb.push_back(e);
    issued++;
    tick();
    cmd_valid = 1'b0;
    for (int g = 0; g < 2; g++)
      chk("accept_strobe", g, 32'({avm_write[g], avm_read[g], cmd_ready[g]}), 32'({v.wr, !v.wr, 1'b0}));
    done = 1'b0;
    for (k = 1; k <= 60 && !done; k++) begin
      waitreq = (k <= v.nwait);
      if (v.busy) begin
        cmd_valid = (k <= 2);
        cmd_write = 1'b1;
        cmd_addr  = 5'd9;
        cmd_wdata = 32'hBAD0_0009;
      end
      tick();
      done = (idx[0] == sb.size()) && (idx[1] == sb.size());
    end
    waitreq   = 1'b0;
    cmd_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got no response expected one within 60 cycles");
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      chk("ready_after", g, 32'(cmd_ready[g]), 32'd1);
      chk("rsp_one_cycle", g, 32'(rsp_valid[g]), 32'd0);
    end
  endtask

  initial begin
    int n [2];
    exp_t e;
    vecs[0] = '{1'b1, 5'd3, 32'h0000_9480,  0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 5'd0, 32'h1111_0000,  0, 1'b0, 32'h0001_F4A0, 1'b0};
    vecs[2] = '{1'b1, 5'd5, 32'hA5A5_0005,  4, 1'b0, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 5'd5, 32'h2222_0000,  2, 1'b0, 32'hA5A5_0005, 1'b0};
    vecs[4] = '{1'b1, 5'd7, 32'h0000_1234, 20, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b0, 5'd3, 32'h3333_0000,  0, 1'b0, 32'h0000_9480, 1'b0};
    vecs[6] = '{1'b0, 5'd7, 32'h4444_0000,  7, 1'b0, 32'h1000_0007, 1'b0};
    vecs[7] = '{1'b0, 5'd1, 32'h5555_0000,  8, 1'b0, 32'h0000_0000, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 32'h6666_0000,  0, 1'b1, 32'h0001_F4A0, 1'b0};
    for (int g = 0; g < 2; g++) begin
      idx[g] = 0; st_cnt[g] = 0; last_st[g] = 0; strobes[g] = 0; rsps[g] = 0;
      st_act[g] = 1'b0; st_wr[g] = 1'b0; st_addr[g] = '0; st_data[g] = '0;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; waitreq = 1'b0;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", g, 32'(cmd_ready[g]), 32'd1);
      chk("rst_strobes", g, 32'({avm_read[g], avm_write[g]}), 32'd0);
      chk("rst_addr", g, 32'(avm_address[g]), 32'd0);
      chk("rst_wdata", g, avm_writedata[g], 32'd0);
      chk("rst_rsp", g, 32'({rsp_valid[g], rsp_err[g]}), 32'd0);
      chk("rst_rdata", g, rsp_rdata[g], 32'd0);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Reset while both instances sit in RD_WAIT.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd0; cmd_wdata = 32'h7777_0000;
    e.wr = 1'b0; e.addr = 5'd0; e.wdata = 32'h7777_0000; e.rdata = 32'h0001_F4A0; e.err = 1'b0; e.nstrobe = 1;
    sb.push_back(e);
    issued++;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("midrst_read", g, 32'(avm_read[g]), 32'd0);
      chk("midrst_ready", g, 32'(cmd_ready[g]), 32'd1);
      chk("midrst_rsp", g, 32'(rsp_valid[g]), 32'd0);
      n[g] = rsps[g];
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    for (int g = 0; g < 2; g++) begin
      chk("midrst_no_rsp", g, 32'(rsps[g] - n[g]), 32'd0);
      chk("midrst_ready_rel", g, 32'(cmd_ready[g]), 32'd1);
    end
    run_cmd('{1'b1, 5'd2, 32'h0000_0004, 0, 1'b0, 32'h0000_0000, 1'b0});
    run_cmd('{1'b0, 5'd2, 32'h8888_0000, 0, 1'b0, 32'h0000_0004, 1'b0});

    for (int g = 0; g < 2; g++) chk("strobe_total", g, 32'(strobes[g]), 32'(issued));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/avalmm_master_ctrl.md
Name: avalmm_master_ctrl

Overview:
Single-transaction Avalon-MM master that drives the oscilloscope register slave from a local command port, such as the GUI or control FSM. It accepts one read or write command at a time and issues it on the Avalon-MM bus, honouring waitrequest. For reads, it captures readdata after a fixed read latency. It returns a response with a status, and a waitrequest timeout prevents lockup.

Parameters:
ADDR_W, 5, Avalon address width
DATA_W, 32, Avalon data width
RD_LATENCY, 1, cycles from accepted read (read high, waitrequest low) to valid readdata; legal range 1..7
TIMEOUT, 255, max consecutive waitrequest-high cycles before abort; legal range 1..65535

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  register address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse, transaction finished
rsp_rdata  out  DATA_W  captured read data; 0 for writes and timeouts
rsp_err  out  1  valid with rsp_valid; 1=timeout
avm_address  out  ADDR_W  Avalon address
avm_write  out  1  Avalon write strobe
avm_read  out  1  Avalon read strobe
avm_writedata  out  DATA_W  Avalon write data
avm_readdata  in  DATA_W  Avalon read data
avm_waitrequest  in  1  slave stall; tie 0 for slaves without it

Behaviour:
- Reset, asynchronous while rst=1:
  - State is IDLE; cmd_ready=1.
  - avm_read=avm_write=0; avm_address=0; avm_writedata=0.
  - rsp_valid=0; rsp_rdata=0; rsp_err=0; all counters 0.
  - Reset mid-transaction drops strobes immediately, and no response is produced.
- All outputs are registered.
- States: IDLE, BUS, RD_WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch addr/wdata into avm_address/avm_writedata, assert avm_write or avm_read per cmd_write, clear the stall counter, and go to BUS.
  - The strobe is visible the cycle after accept.
- BUS:
  - cmd_ready=0; address, data and strobe are held stable.
  - If avm_waitrequest=0, the transfer completes this cycle and the strobe deasserts next cycle.
    - Write: go to RESP with rsp_err=0, rsp_rdata=0.
    - Read: load the latency counter with RD_LATENCY-1 and go to RD_WAIT.
  - If avm_waitrequest=1, increment the stall counter.
    - When the counter reaches TIMEOUT, deassert the strobe and go to RESP with rsp_err=1, rsp_rdata=0.
- RD_WAIT:
  - Count down. When the counter is 0, sample avm_readdata into rsp_rdata and go to RESP.
  - With RD_LATENCY=1, the sample happens on the cycle right after completion in BUS, which matches a slave with registered readdata.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE (cmd_ready=1 next cycle).
  - rsp_rdata and rsp_err hold until the next response.
- Throughput: no pipelining; at most one outstanding transaction.
  - Back-to-back zero-wait write: accept at cycle 0, strobe at cycle 1, rsp_valid at cycle 2, cmd_ready at cycle 3.
- cmd_valid while cmd_ready=0 is ignored, and its fields are not sampled.
- avm_read and avm_write are never both 1.
- Waitrequest timeout counting starts on the first strobe cycle; stall counter width is 16 bits.

Test Plan:
1. Write, no wait: cmd write addr=3 wdata=0x0000_9480, waitrequest=0 -> avm_write high exactly 1 cycle with address 3, data 0x9480; rsp_valid 1 cycle later; rsp_err=0, rsp_rdata=0.
2. Read, RD_LATENCY=1: slave model returns 0x000_1F4A0 registered for addr 0 -> avm_read 1 cycle; rsp_rdata=0x0001F4A0 and rsp_valid 2 cycles after the strobe cycle.
3. Waitrequest stall: waitrequest high 4 cycles on a write to addr 5 -> strobe, address and data held stable 5 cycles; single response with rsp_err=0.
4. Timeout with TIMEOUT=8: waitrequest stuck high -> strobe drops after 8 stall cycles; rsp_valid with rsp_err=1, rsp_rdata=0; cmd_ready returns the next cycle; a following read succeeds normally.
5. Busy rejection plus RD_LATENCY=3: issue a second cmd_valid during an active read -> ignored, with no extra bus strobe; the first read samples readdata exactly 3 cycles after completion.
6. Reset mid-read: assert rst while in RD_WAIT -> avm_read=0, rsp_valid never pulses, cmd_ready=1 after release; a fresh write to addr 2 value 0x0004 completes correctly.
